// File: rtl/brc_pkg.sv
// Shared constants for the RV32I branch comparator: default operand width
// and the nibble-slice geometry used by the structural compare tree.
package brc_pkg;

  // Default operand width (RV32I register width).
  localparam int BRC_DATA_W = 32;

  // Width of one compare slice; the tree is built from nibbles.
  localparam int BRC_SLICE_W = 4;

  // Number of slices for the default operand width.
  localparam int BRC_NUM_SLICES = BRC_DATA_W / BRC_SLICE_W;

endpackage : brc_pkg

// File: rtl/brc_cmp4.sv
// 4-bit unsigned slice comparator. Produces "a less than b" and "a equal b"
// from per-bit terms, resolving MSB-first, without relational operators.
module brc_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt,
  output logic       eq
);

  logic [3:0] bit_eq_s;
  logic [3:0] bit_lt_s;

  // A bit position is "equal" when both bits match, "less" when a=0 and b=1.
  assign bit_eq_s = ~(a ^ b);
  assign bit_lt_s = ~a & b;

  // The highest differing bit decides the ordering of the slice.
  assign lt = bit_lt_s[3] |
              (bit_eq_s[3] & (bit_lt_s[2] |
              (bit_eq_s[2] & (bit_lt_s[1] |
              (bit_eq_s[1] &  bit_lt_s[0])))));

  assign eq = &bit_eq_s;

endmodule : brc_cmp4

// File: rtl/brc.sv
// Branch comparator for the RV32I core. Reports rs1 < rs2 (signed or
// unsigned as chosen by i_br_un) and rs1 == rs2. The result is built from
// nibble slices combined MSB-first, with the signed fix-up applied only at
// the top bit. An optional output register stage serves pipelined builds.
module brc
  import brc_pkg::*;
#(
  parameter int DATA_W  = BRC_DATA_W,
  parameter int REG_OUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic              i_br_un,
  output logic              o_br_less,
  output logic              o_br_equal
);

  localparam int  NUM_SLICES = DATA_W / BRC_SLICE_W;
  localparam bit  USE_REG    = (REG_OUT != 0);

  logic [NUM_SLICES-1:0] slice_lt_s;
  logic [NUM_SLICES-1:0] slice_eq_s;

  logic lt_acc_s;
  logic eq_acc_s;
  logic ult_s;
  logic equal_s;
  logic msb_diff_s;
  logic less_s;

  logic less_r;
  logic equal_r;

  // One unsigned comparator per nibble of the operands.
  for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
    brc_cmp4 u_cmp4 (
      .a  (i_rs1_data[g*BRC_SLICE_W +: BRC_SLICE_W]),
      .b  (i_rs2_data[g*BRC_SLICE_W +: BRC_SLICE_W]),
      .lt (slice_lt_s[g]),
      .eq (slice_eq_s[g])
    );
  end

  // Fold the slice results MSB-first: a lower slice only matters while
  // every slice above it is equal.
  always_comb begin
    lt_acc_s = 1'b0;
    eq_acc_s = 1'b1;
    for (int i = NUM_SLICES - 1; i >= 0; i--) begin
      lt_acc_s = lt_acc_s | (eq_acc_s & slice_lt_s[i]);
      eq_acc_s = eq_acc_s & slice_eq_s[i];
    end
    ult_s   = lt_acc_s;
    equal_s = eq_acc_s;
  end

  assign msb_diff_s = i_rs1_data[DATA_W-1] ^ i_rs2_data[DATA_W-1];

  // Signed fix-up: with differing sign bits the negative operand (MSB=1)
  // is the smaller one; with equal sign bits the unsigned order holds.
  always_comb begin
    less_s = 1'b0;
    if (i_br_un) begin
      less_s = ult_s;
    end else if (msb_diff_s) begin
      less_s = i_rs1_data[DATA_W-1];
    end else begin
      less_s = ult_s;
    end
  end

  // Optional pipeline register; reset clears both flags asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      less_r  <= 1'b0;
      equal_r <= 1'b0;
    end else begin
      less_r  <= less_s;
      equal_r <= equal_s;
    end
  end

  assign o_br_less  = USE_REG ? less_r  : less_s;
  assign o_br_equal = USE_REG ? equal_r : equal_s;

endmodule : brc

// File: tb/tb_brc.sv
// Self-checking bench for brc. Drives one combinational (REG_OUT=0) and one
// registered (REG_OUT=1) instance from the same stimulus; expected flags are
// queued when a vector is applied and popped when each instance's result is due.
module tb_brc;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        un;

  logic c_less, c_equal;
  logic r_less, r_equal;

  int errors;
  int checks;

  logic [1:0] q_comb[$];
  logic [1:0] q_reg[$];

  brc #(.DATA_W(32), .REG_OUT(0)) dut_comb (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rs1_data (a),
    .i_rs2_data (b),
    .i_br_un    (un),
    .o_br_less  (c_less),
    .o_br_equal (c_equal)
  );

  brc #(.DATA_W(32), .REG_OUT(1)) dut_reg (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rs1_data (a),
    .i_rs2_data (b),
    .i_br_un    (un),
    .o_br_less  (r_less),
    .o_br_equal (r_equal)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got {less,equal}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Golden model: {less, equal}.
  function automatic logic [1:0] model(input logic [31:0] av, input logic [31:0] bv,
                                       input logic u);
    logic lt;
    if (u) lt = (av < bv);
    else   lt = ($signed(av) < $signed(bv));
    return {lt, (av == bv)};
  endfunction

  // Apply one vector at the falling edge; check the combinational instance
  // 1 ns later and the registered instance 1 ns after the next rising edge.
  task automatic apply(input logic [31:0] av, input logic [31:0] bv, input logic u,
                       input string tag);
    logic [1:0] e;
    @(negedge clk);
    a  = av;
    b  = bv;
    un = u;
    q_comb.push_back(model(av, bv, u));
    q_reg.push_back(model(av, bv, u));
    #1;
    e = q_comb.pop_front();
    chk({tag, "_comb"}, {c_less, c_equal}, e);
    @(posedge clk);
    #1;
    e = q_reg.pop_front();
    chk({tag, "_reg"}, {r_less, r_equal}, e);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    a      = 32'h1234_5678;
    b      = 32'h1234_5678;
    un     = 1'b0;

    // Reset state: registered flags held at 0, combinational path unaffected.
    #2;
    chk("rst_reg", {r_less, r_equal}, 2'b00);
    chk("rst_comb", {c_less, c_equal}, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_reg", {r_less, r_equal}, 2'b00);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    apply(32'h1234_5678, 32'h1234_5678, 1'b0, "eq_s");
    apply(32'h1234_5678, 32'h1234_5678, 1'b1, "eq_u");
    apply(32'h8000_0000, 32'h0000_0001, 1'b0, "sign_s");
    apply(32'h8000_0000, 32'h0000_0001, 1'b1, "sign_u");
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "ext_s");
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ext_u");
    apply(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "swap_s");
    apply(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "swap_u");
    apply(32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0, "lownib_s");
    apply(32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b1, "lownib_u");
    apply(32'h7FFF_FFFF, 32'h7FFF_FFFE, 1'b0, "lownib_rev");
    apply(32'h0001_0000, 32'h0000_FFFF, 1'b1, "carry_u");

    // Random sweeps; every tenth pair is forced equal.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = (i % 10 == 0) ? ra : $urandom;
      apply(ra, rb, 1'b1, "rnd_u");
    end
    for (int i = 0; i < 100; i++) begin
      ra = $random;
      rb = (i % 10 == 0) ? ra : $random;
      apply(ra, rb, 1'b0, "rnd_s");
    end

    // Reset asserted mid-operation clears registered flags at once.
    apply(32'd5, 32'd5, 1'b1, "pre_rst");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg", {r_less, r_equal}, 2'b00);
    chk("mid_rst_comb", {c_less, c_equal}, 2'b01);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {r_less, r_equal}, 2'b00);

    // Release and apply 5 vs 5: result appears exactly one edge later.
    @(negedge clk);
    rst_n = 1'b1;
    a     = 32'd5;
    b     = 32'd5;
    un    = 1'b0;
    #1;
    chk("post_rst_noedge", {r_less, r_equal}, 2'b00);
    @(posedge clk);
    #1;
    chk("post_rst_edge1", {r_less, r_equal}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_brc
